r_response_memory: RTL and testbench
====================================

# r_response_memory

Shared beat store for the read-response reorder path. It holds the R beats that `r_ordering_unit` cannot forward in order, keyed by unique id (uid). On request it returns them per uid in arrival order. A pool of `NUM_SLOTS` beat slots is shared by all uids through per-uid linked lists, so storage tracks actual traffic rather than the worst case per uid.

## Interface
- `ID_WIDTH`, 4: uid width; `2**ID_WIDTH` uid lists.
- `DATA_WIDTH`, 64: R data width.
- `RESP_WIDTH`, 2: R resp width.
- `NUM_SLOTS`, 16: beat slots in the shared pool.
- `MAX_LEN`, 8: maximum beats held per uid.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `r_store`  r_if.receiver  –  store port.
  - Fields: `id` (uid), `data`, `resp`, `last`.
  - `valid`: store request; `ready`: beat accepted.
- `release_uid`  in  ID_WIDTH  uid whose head beat is presented on `r_release`.
- `r_release`  r_if.sender  –  release port.
  - Fields: `id` (= `release_uid`), `data`, `resp`, `last`.
  - `valid`: uid has a stored beat; `ready`: consumer pops the head beat.
- `free_count`  out  $clog2(NUM_SLOTS+1)  unused slots, registered.

## Operation
- State:
  - `slot_data[NUM_SLOTS]` holds {data, resp, last}.
  - `next_ptr[NUM_SLOTS]` links slots within a list.
  - `free_map[NUM_SLOTS]` marks free slots.
  - Per uid: `head`, `tail` and `cnt`, where `cnt` is $clog2(MAX_LEN+1) bits.
- Store accept:
  - `r_store.ready = (free_count != 0) && (cnt[r_store.id] != MAX_LEN)`.
  - This is combinational on `id`, never on `valid`.
- Slot choice: the lowest-index free slot, by priority encode of `free_map`.
- Store handshake:
  - Write the beat into the chosen slot and clear its `free_map` bit.
  - If `cnt == 0`: set `head = tail = slot`.
  - Otherwise: set `next_ptr[tail] = slot` and `tail = slot`.
  - Increment `cnt`.
- Release presentation:
  - `r_release.valid = (cnt[release_uid] != 0)`.
  - Fields are read asynchronously from `slot_data[head[release_uid]]`.
  - When valid is 0, fields are don't-care; drive `'0`.
- Release handshake:
  - Set the `free_map` bit of `head`.
  - Set `head = next_ptr[head]` and decrement `cnt`.
- Simultaneous store and release, different uids: both proceed independently.
- Simultaneous store and release, same uid:
  - If `cnt == 1`: the new slot becomes both head and tail, and `cnt` stays 1.
  - If `cnt > 1`: append and pop both occur, and `cnt` is unchanged.
- A slot freed in cycle N is not selectable for a store until cycle N+1. Allocation uses the registered `free_map` only.
- `free_count` update: next = current − hs_store + hs_release, registered.
- Error rules:
  - A release handshake with `valid == 0` cannot occur, because ready is a request and is ignored when valid is low.
  - Storing to a full uid is blocked by `ready`.

## Timing
- Release read has zero latency: `r_release.*` is combinational from `release_uid` and registered state.
- A stored beat is visible on `r_release` in the cycle after its store handshake, never in the same cycle.
- Store `ready` does not depend on `r_release` in the same cycle, so there is no combinational loop with `r_ordering_unit`.
- Reset, asynchronous:
  - `free_map` is all ones, every `cnt` is 0, `head`/`tail`/`next_ptr` are 0 and `free_count` is `NUM_SLOTS`.
  - `r_store.ready` is 1 and `r_release.valid` is 0.
  - `slot_data` is not reset.
- Reset mid-burst discards all stored beats immediately. No partial list survives.

## Structure
- Shared package `rob_pkg`:
  - `r_beat_t` {data, resp, last}.
  - Width localparams for uid, slot index and count.
- Sub-module `lowest_free_enc`: parameterised priority encoder. It outputs the index and an any-free flag.
- Slot and next-pointer arrays stay as flop arrays, with no SRAM macro.

## Test plan
- Reset then idle:
  - `free_count = 16`, `r_store.ready = 1`.
  - `release_uid = 5` gives `r_release.valid = 0`.
- Store uid 3 beats D0, D1, D2 (last on D2), then `release_uid = 3` with ready held high:
  - Output is D0, D1, D2 on consecutive cycles, with `last` only on D2.
  - `free_count` goes 13 → 16.
- Interleave stores to uid 1 and uid 9 (A0, B0, A1, B1):
  - Releasing uid 9 returns B0, B1.
  - Releasing uid 1 then returns A0, A1.
  - Slots 1 and 3 are freed first.
- Fill all 16 slots:
  - `ready = 0` on the 17th store.
  - A release in cycle N gives `ready = 1` in N+1, and the store goes into the freed slot index.
- Uid 2 holds one beat; same-cycle release of it and store of new beat X to uid 2:
  - Next cycle: `valid = 1`, `data = X`, `cnt = 1`.
- 8 beats to uid 4: a 9th store to uid 4 sees `ready = 0`, while a store to uid 5 is accepted in the same cycle.
- Assert rst during a 4-beat release:
  - All outputs return to reset values immediately.
  - `free_count = 16` on the first cycle after reset deasserts.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and default widths for the read-response reorder path.
package rob_pkg;

  localparam int unsigned ROB_ID_W      = 4;
  localparam int unsigned ROB_DATA_W    = 64;
  localparam int unsigned ROB_RESP_W    = 2;
  localparam int unsigned ROB_NUM_SLOTS = 16;
  localparam int unsigned ROB_MAX_LEN   = 8;
  localparam int unsigned ROB_SLOT_W    = $clog2(ROB_NUM_SLOTS);
  localparam int unsigned ROB_CNT_W     = $clog2(ROB_MAX_LEN + 1);
  localparam int unsigned ROB_FREE_W    = $clog2(ROB_NUM_SLOTS + 1);

  typedef struct packed {
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_RESP_W-1:0] resp;
    logic                  last;
  } r_beat_t;

endpackage

// File: rtl/r_if.sv
// AXI-style R channel bundle with valid/ready handshake.
interface r_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport receiver (input valid, id, data, resp, last, output ready);
  modport sender   (output valid, id, data, resp, last, input ready);
endinterface

// File: rtl/lowest_free_enc.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_free_enc #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/r_response_memory.sv
// Shared R-beat pool: per-uid linked lists over a common slot array,
// filled out of order and drained per uid in arrival order.
module r_response_memory
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = ROB_ID_W,
  parameter int unsigned DATA_WIDTH = ROB_DATA_W,
  parameter int unsigned RESP_WIDTH = ROB_RESP_W,
  parameter int unsigned NUM_SLOTS  = ROB_NUM_SLOTS,
  parameter int unsigned MAX_LEN    = ROB_MAX_LEN
) (
  input  logic                             clk,
  input  logic                             rst,
  r_if.receiver                            r_store,
  input  logic [ID_WIDTH-1:0]              release_uid,
  r_if.sender                              r_release,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   free_count
);

  localparam int unsigned NUM_UIDS = 2 ** ID_WIDTH;
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned FREE_W   = $clog2(NUM_SLOTS + 1);

  r_beat_t             slot_data [NUM_SLOTS];
  logic [SLOT_W-1:0]   next_ptr  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_map;
  logic [SLOT_W-1:0]   head      [NUM_UIDS];
  logic [SLOT_W-1:0]   tail      [NUM_UIDS];
  logic [CNT_W-1:0]    cnt       [NUM_UIDS];

  logic [SLOT_W-1:0]   alloc_idx;
  logic                any_free;
  logic [ID_WIDTH-1:0] store_uid;
  logic [SLOT_W-1:0]   rel_head;
  logic                hs_store;
  logic                hs_release;
  logic                same_uid;
  r_beat_t             store_beat;
  r_beat_t             rel_beat;

  lowest_free_enc #(.N(NUM_SLOTS), .IW(SLOT_W)) u_enc (
    .req (free_map),
    .idx (alloc_idx),
    .any (any_free)
  );

  assign store_uid  = r_store.id;
  assign store_beat = '{data: ROB_DATA_W'(r_store.data),
                        resp: ROB_RESP_W'(r_store.resp),
                        last: r_store.last};

  // Ready depends only on registered state and the store id, never on release.
  assign r_store.ready = (free_count != '0) && (cnt[store_uid] != CNT_W'(MAX_LEN));
  assign hs_store      = r_store.valid && r_store.ready && any_free;

  assign rel_head        = head[release_uid];
  assign r_release.valid = (cnt[release_uid] != '0);
  assign rel_beat        = r_release.valid ? slot_data[rel_head] : '0;
  assign r_release.id    = release_uid;
  assign r_release.data  = DATA_WIDTH'(rel_beat.data);
  assign r_release.resp  = RESP_WIDTH'(rel_beat.resp);
  assign r_release.last  = rel_beat.last;
  assign hs_release      = r_release.valid && r_release.ready;
  assign same_uid        = (store_uid == release_uid);

  // List and free-pool bookkeeping; store updates are placed after the pop
  // so a same-uid store overrides the popped head when the list was 1 deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map   <= '1;
      free_count <= FREE_W'(NUM_SLOTS);
      for (int i = 0; i < int'(NUM_SLOTS); i++) next_ptr[i] <= '0;
      for (int u = 0; u < int'(NUM_UIDS); u++) begin
        head[u] <= '0;
        tail[u] <= '0;
        cnt[u]  <= '0;
      end
    end else begin
      if (hs_release) begin
        free_map[rel_head] <= 1'b1;
        head[release_uid]  <= next_ptr[rel_head];
        cnt[release_uid]   <= cnt[release_uid] - CNT_W'(1);
      end
      if (hs_store) begin
        free_map[alloc_idx] <= 1'b0;
        tail[store_uid]     <= alloc_idx;
        if ((cnt[store_uid] == '0) ||
            (hs_release && same_uid && (cnt[store_uid] == CNT_W'(1))))
          head[store_uid] <= alloc_idx;
        else
          next_ptr[tail[store_uid]] <= alloc_idx;
        cnt[store_uid] <= (hs_release && same_uid) ? cnt[store_uid]
                                                   : cnt[store_uid] + CNT_W'(1);
      end
      free_count <= free_count - FREE_W'(hs_store) + FREE_W'(hs_release);
    end
  end

  // Beat payload storage is not reset; validity comes from the list counts.
  always_ff @(posedge clk) begin
    if (hs_store) slot_data[alloc_idx] <= store_beat;
  end

endmodule

// File: tb/tb_r_response_memory.sv
// Scoreboard bench for r_response_memory: per-uid FIFO queues model the lists.
module tb_r_response_memory;
  import rob_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] release_uid;
  logic [4:0] free_count;

  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) st_if ();
  r_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) rl_if ();

  r_response_memory dut (
    .clk         (clk),
    .rst         (rst),
    .r_store     (st_if),
    .release_uid (release_uid),
    .r_release   (rl_if),
    .free_count  (free_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  r_beat_t mq [16][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs against the queue model and advances it.
  always @(negedge clk) begin
    int      total;
    bit      exp_rdy;
    bit      exp_v;
    int      su;
    int      ru;
    r_beat_t b;
    if (rst) begin
      for (int u = 0; u < 16; u++) mq[u].delete();
      chk("rst_store_ready", 64'(st_if.ready), 64'd1);
      chk("rst_rel_valid", 64'(rl_if.valid), 64'd0);
      chk("rst_free_count", 64'(free_count), 64'd16);
    end else begin
      total = 0;
      for (int u = 0; u < 16; u++) total += mq[u].size();
      su      = int'(st_if.id);
      ru      = int'(release_uid);
      exp_rdy = (total < 16) && (mq[su].size() < 8);
      exp_v   = (mq[ru].size() != 0);
      chk("store_ready", 64'(st_if.ready), 64'(exp_rdy));
      chk("free_count", 64'(free_count), 64'(16 - total));
      chk("rel_valid", 64'(rl_if.valid), 64'(exp_v));
      chk("rel_id", 64'(rl_if.id), 64'(ru));
      if (exp_v) begin
        b = mq[ru][0];
        chk("rel_data", rl_if.data, b.data);
        chk("rel_resp", 64'(rl_if.resp), 64'(b.resp));
        chk("rel_last", 64'(rl_if.last), 64'(b.last));
        if (rl_if.ready) void'(mq[ru].pop_front());
      end else begin
        chk("rel_data_idle", rl_if.data, 64'd0);
      end
      if (st_if.valid && exp_rdy)
        mq[su].push_back('{data: st_if.data, resp: st_if.resp, last: st_if.last});
    end
  end

  task automatic step(input bit sv, input int sid, input logic [63:0] d, input bit l,
                      input int ru, input bit rr);
    st_if.valid  = sv;
    st_if.id     = 4'(sid);
    st_if.data   = d;
    st_if.resp   = d[1:0];
    st_if.last   = l;
    release_uid  = 4'(ru);
    rl_if.ready  = rr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drain();
    for (int u = 0; u < 16; u++)
      for (int k = 0; k < 9; k++) step(1'b0, 0, 64'd0, 1'b0, u, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    st_if.valid = 1'b0; st_if.id = '0; st_if.data = '0; st_if.resp = '0; st_if.last = 1'b0;
    release_uid = 4'd5; rl_if.ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 0, 64'd0, 1'b0, 5, 1'b0);

    // uid 3 burst, then in-order drain
    step(1'b1, 3, 64'hD0, 1'b0, 5, 1'b0);
    step(1'b1, 3, 64'hD1, 1'b0, 5, 1'b0);
    step(1'b1, 3, 64'hD2, 1'b1, 5, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 0, 64'd0, 1'b0, 3, 1'b1);

    // interleaved uids 1 and 9
    step(1'b1, 1, 64'hA0, 1'b0, 0, 1'b0);
    step(1'b1, 9, 64'hB0, 1'b0, 0, 1'b0);
    step(1'b1, 1, 64'hA1, 1'b1, 0, 1'b0);
    step(1'b1, 9, 64'hB1, 1'b1, 0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 0, 64'd0, 1'b0, 9, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 64'd0, 1'b0, 1, 1'b1);

    // fill the pool, 17th store blocked, release frees a slot for next cycle
    for (int i = 0; i < 16; i++) step(1'b1, i % 4, rnd64(), 1'b0, 15, 1'b0);
    step(1'b1, 0, rnd64(), 1'b0, 15, 1'b0);
    step(1'b1, 0, rnd64(), 1'b0, 2, 1'b1);
    step(1'b1, 0, 64'hF00D, 1'b1, 15, 1'b0);
    step(1'b1, 1, rnd64(), 1'b0, 15, 1'b0);
    drain();

    // same-cycle release and store on a one-beat uid
    step(1'b1, 2, 64'h1111, 1'b0, 0, 1'b0);
    step(1'b1, 2, 64'h5A5A, 1'b1, 2, 1'b1);
    step(1'b0, 0, 64'd0, 1'b0, 2, 1'b0);
    step(1'b0, 0, 64'd0, 1'b0, 2, 1'b1);
    step(1'b0, 0, 64'd0, 1'b0, 2, 1'b0);

    // per-uid cap: uid 4 full, uid 5 still accepted
    for (int i = 0; i < 8; i++) step(1'b1, 4, rnd64(), i == 7, 0, 1'b0);
    step(1'b1, 4, rnd64(), 1'b0, 0, 1'b0);
    step(1'b1, 5, rnd64(), 1'b1, 0, 1'b0);
    drain();

    // reset in the middle of a 4-beat release
    for (int i = 0; i < 4; i++) step(1'b1, 6, rnd64(), i == 3, 0, 1'b0);
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b1);
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b1);
    rst = 1'b1;
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b1);
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b1);
    rst = 1'b0;
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b1);
    step(1'b0, 0, 64'd0, 1'b0, 6, 1'b0);

    // randomized traffic concentrated on a few uids to hit full conditions
    for (int c = 0; c < 3000; c++) begin
      int sid;
      int ru;
      sid = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      ru  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 60, sid, rnd64(), 1'($urandom_range(0, 1)), ru,
           $urandom_range(0, 99) < 45);
    end
    drain();
    step(1'b0, 0, 64'd0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
